// File: rtl/gray_step_decoder.sv
// -----------------------------------------------------------------------------
// gray_step_decoder
//
// Receive end of a Gray-coded position/count link. Each sampled Gray word is
// decoded to binary and compared against the previous decoded value; a legal
// move is +1, -1 or hold (modulo 2^WIDTH). The block reports the direction of
// the last move, a lock indication after LOCK_CNT consecutive good +/-1 steps,
// a one-cycle pulse on illegal steps and a saturating illegal-step counter.
//
// Pipeline: gray_valid at cycle N -> bin_valid at cycle N+2, 1 sample/cycle.
//
// Optional feature macro: GRAY_STICKY_FAULT_EN
//   defined     : FAULT state is sticky; only rst or clr_err return to UNLOCKED.
//   not defined : FAULT returns to UNLOCKED on the next classified sample.
//
// Parameters
//   WIDTH      code width in bits (>=2)
//   LOCK_CNT   consecutive good +/-1 steps needed to lock (>=1)
//   ERR_CNT_W  width of the saturating error counter
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active-high
//   gray_in     in   Gray-coded input word
//   gray_valid  in   gray_in qualifier
//   clr_err     in   synchronous clear of err_count (and sticky fault)
//   bin_out     out  decoded binary value, held between samples
//   bin_valid   out  one-cycle pulse per decoded sample
//   dir_up      out  1 = last +/-1 step was up, 0 = down
//   step_err    out  one-cycle pulse with bin_valid on an illegal step
//   locked      out  high while in LOCKED state
//   err_count   out  saturating count of illegal steps
// -----------------------------------------------------------------------------
module gray_step_decoder #(
   parameter int WIDTH     = 4,
   parameter int LOCK_CNT  = 3,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 gray_valid,
   input  logic                 clr_err,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 bin_valid,
   output logic                 dir_up,
   output logic                 step_err,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int                   RUN_W    = $clog2(LOCK_CNT + 1);
   localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(LOCK_CNT - 1);
   localparam logic [RUN_W-1:0]     RUN_ONE  = RUN_W'(1);
   localparam logic [WIDTH-1:0]     STEP_UP  = WIDTH'(1);
   localparam logic [WIDTH-1:0]     STEP_DN  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]     STEP_0   = {WIDTH{1'b0}};
   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
   localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_FAULT    = 2'd2
   } state_t;

   // Stage 1: input capture
   logic [WIDTH-1:0]     g_q;
   logic                 v_q;

   // Stage 2: decoded sample and tracking state
   logic [WIDTH-1:0]     bin_q,       bin_d;
   logic                 bin_valid_q, bin_valid_d;
   logic [WIDTH-1:0]     prev_q,      prev_d;
   logic                 has_prev_q,  has_prev_d;
   logic                 dir_q,       dir_d;
   logic                 step_err_q,  step_err_d;
   state_t               state_q,     state_d;
   logic [RUN_W-1:0]     run_q,       run_d;
   logic [ERR_CNT_W-1:0] err_q,       err_d;

   logic [WIDTH-1:0]     dec_bin;
   logic [WIDTH-1:0]     step_diff;
   logic                 classify;
   logic                 is_up;
   logic                 is_down;
   logic                 is_bad;

   // Gray -> binary: bit i is the XOR of all Gray bits at or above i.
   // Written as a reduction per bit so there is no chained dependency
   // within a single vector.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_dec
         assign dec_bin[gi] = ^g_q[WIDTH-1:gi];
      end
   endgenerate

   // Modular difference: wrap-around (max->0, 0->max) falls out naturally.
   assign step_diff = dec_bin - prev_q;
   // The very first sample after reset only seeds prev.
   assign classify  = v_q & has_prev_q;
   assign is_up     = classify & (step_diff == STEP_UP);
   assign is_down   = classify & (step_diff == STEP_DN);
   assign is_bad    = classify & (step_diff != STEP_UP) & (step_diff != STEP_DN)
                               & (step_diff != STEP_0);

   always_comb begin
      bin_d       = bin_q;
      bin_valid_d = v_q;
      prev_d      = prev_q;
      has_prev_d  = has_prev_q;
      dir_d       = dir_q;
      step_err_d  = 1'b0;
      state_d     = state_q;
      run_d       = run_q;
      err_d       = err_q;

      if (v_q) begin
         bin_d      = dec_bin;
         prev_d     = dec_bin;
         has_prev_d = 1'b1;
      end

      if (is_up) begin
         dir_d = 1'b1;
      end
      if (is_down) begin
         dir_d = 1'b0;
      end

      if (is_bad) begin
         step_err_d = 1'b1;
         if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_ONE;
         end
      end

      if (classify) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (is_up || is_down) begin
                  if (run_q == RUN_LAST) begin
                     state_d = ST_LOCKED;
                     run_d   = '0;
                  end else begin
                     run_d = run_q + RUN_ONE;
                  end
               end else if (is_bad) begin
                  run_d = '0;
               end
            end
            ST_LOCKED: begin
               if (is_bad) begin
                  state_d = ST_FAULT;
               end
            end
            ST_FAULT: begin
`ifdef GRAY_STICKY_FAULT_EN
               // Sticky: classified samples never leave FAULT.
               state_d = ST_FAULT;
`else
               // Recovery sample is consumed here and does not count
               // toward the lock run (its error, if any, still counts).
               state_d = ST_UNLOCKED;
               run_d   = '0;
`endif
            end
            default: begin
               state_d = ST_UNLOCKED;
               run_d   = '0;
            end
         endcase
      end

      // Clear wins over a same-cycle increment; step_err still pulses.
      if (clr_err) begin
         err_d = '0;
`ifdef GRAY_STICKY_FAULT_EN
         if (state_d == ST_FAULT) begin
            state_d = ST_UNLOCKED;
            run_d   = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         g_q         <= '0;
         v_q         <= 1'b0;
         bin_q       <= '0;
         bin_valid_q <= 1'b0;
         prev_q      <= '0;
         has_prev_q  <= 1'b0;
         dir_q       <= 1'b0;
         step_err_q  <= 1'b0;
         state_q     <= ST_UNLOCKED;
         run_q       <= '0;
         err_q       <= '0;
      end else begin
         if (gray_valid) begin
            g_q <= gray_in;
         end
         v_q         <= gray_valid;
         bin_q       <= bin_d;
         bin_valid_q <= bin_valid_d;
         prev_q      <= prev_d;
         has_prev_q  <= has_prev_d;
         dir_q       <= dir_d;
         step_err_q  <= step_err_d;
         state_q     <= state_d;
         run_q       <= run_d;
         err_q       <= err_d;
      end
   end

   assign bin_out   = bin_q;
   assign bin_valid = bin_valid_q;
   assign dir_up    = dir_q;
   assign step_err  = step_err_q;
   assign locked    = (state_q == ST_LOCKED);
   assign err_count = err_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_gray_step_decoder
//
// Directed stimulus against two instances of gray_step_decoder (default
// ERR_CNT_W and ERR_CNT_W=2, same inputs). A behavioural model tracks the
// expected outputs from the decoding/step rules and is compared every cycle;
// literal expectations per scenario pin the model.
// -----------------------------------------------------------------------------
module tb_gray_step_decoder;

   localparam int W    = 4;
   localparam int LOCK = 3;
   localparam int MODV = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] gray_in;
   logic         gray_valid;
   logic         clr_err;

   logic [W-1:0] bin_out,   bin_out2;
   logic         bin_valid, bin_valid2;
   logic         dir_up,    dir_up2;
   logic         step_err,  step_err2;
   logic         locked,    locked2;
   logic [7:0]   err_count;
   logic [1:0]   err_count2;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gray_step_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
      .clr_err(clr_err), .bin_out(bin_out), .bin_valid(bin_valid),
      .dir_up(dir_up), .step_err(step_err), .locked(locked),
      .err_count(err_count)
   );

   gray_step_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
      .clr_err(clr_err), .bin_out(bin_out2), .bin_valid(bin_valid2),
      .dir_up(dir_up2), .step_err(step_err2), .locked(locked2),
      .err_count(err_count2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // states: 0 unlocked, 1 locked, 2 fault
   int m_ok = 0;
   int m_v1, m_g1, m_has, m_prev, m_bin, m_bv, m_dir, m_se;
   int m_state, m_run, m_err, m_err2;

   function automatic int g2b(input int g);
      int b;
      b = 0;
      for (int k = 0; k < W; k++) b = b ^ (g >> k);
      return b % MODV;
   endfunction

   task automatic model_step();
      int b, d;
      if (rst) begin
         m_v1 = 0; m_g1 = 0; m_has = 0; m_prev = 0; m_bin = 0; m_bv = 0;
         m_dir = 0; m_se = 0; m_state = 0; m_run = 0; m_err = 0; m_err2 = 0;
         m_ok = 1;
      end else begin
         m_bv = 0;
         m_se = 0;
         if (m_v1 != 0) begin
            b = g2b(m_g1);
            if (m_has != 0) begin
               d = (b - m_prev + MODV) % MODV;
               if (d == 1) m_dir = 1;
               if (d == MODV - 1) m_dir = 0;
               if (d != 0 && d != 1 && d != MODV - 1) begin
                  m_se = 1;
                  if (m_err < 255) m_err++;
                  if (m_err2 < 3) m_err2++;
               end
               if (m_state == 0) begin
                  if (d == 1 || d == MODV - 1) begin
                     m_run++;
                     if (m_run == LOCK) begin m_state = 1; m_run = 0; end
                  end else if (m_se == 1) begin
                     m_run = 0;
                  end
               end else if (m_state == 1) begin
                  if (m_se == 1) m_state = 2;
               end else begin
`ifndef GRAY_STICKY_FAULT_EN
                  m_state = 0;
                  m_run   = 0;
`endif
               end
            end
            m_bin = b; m_bv = 1; m_prev = b; m_has = 1;
         end
         if (clr_err) begin
            m_err = 0; m_err2 = 0;
`ifdef GRAY_STICKY_FAULT_EN
            if (m_state == 2) begin m_state = 0; m_run = 0; end
`endif
         end
         m_v1 = gray_valid ? 1 : 0;
         m_g1 = int'(gray_in);
      end
   endtask

   always @(posedge clk) model_step();

   // ---------------- per-cycle compare + observation log ----------------
   int q_bin[$], q_lock[$], q_dir[$], q_se[$], q_err[$], q_cyc[$];

   always @(negedge clk) begin
      if (m_ok != 0) begin
         check("bin_valid",  32'(bin_valid),  32'(m_bv));
         check("bin_out",    32'(bin_out),    32'(m_bin));
         check("dir_up",     32'(dir_up),     32'(m_dir));
         check("step_err",   32'(step_err),   32'(m_se));
         check("locked",     32'(locked),     32'(m_state == 1));
         check("err_count",  32'(err_count),  32'(m_err));
         check("bin_valid2", 32'(bin_valid2), 32'(m_bv));
         check("err_count2", 32'(err_count2), 32'(m_err2));
         if (bin_valid) begin
            q_bin.push_back(int'(bin_out));
            q_lock.push_back(int'(locked));
            q_dir.push_back(int'(dir_up));
            q_se.push_back(int'(step_err));
            q_err.push_back(int'(err_count));
            q_cyc.push_back(cyc);
            $display("sample: bin_out=%0d dir_up=%0d step_err=%0d locked=%0d err_count=%0d",
                     bin_out, dir_up, step_err, locked, err_count);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_log();
      q_bin.delete(); q_lock.delete(); q_dir.delete();
      q_se.delete();  q_err.delete();  q_cyc.delete();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; gray_valid = 1'b0; clr_err = 1'b0;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
      clear_log();
   endtask

   task automatic send(input logic [W-1:0] g);
      gray_in = g; gray_valid = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      gray_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
   endtask

   function automatic int sum_se();
      int s;
      s = 0;
      foreach (q_se[i]) s += q_se[i];
      return s;
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      int t_in;
      int e1[5] = '{0, 1, 2, 3, 4};
      int e2[5] = '{13, 14, 15, 0, 1};
      int e3[5] = '{2, 1, 0, 15, 15};

      rst = 1'b1; gray_in = '0; gray_valid = 1'b0; clr_err = 1'b0;

      // 1: basic up count, latency, lock at the 3rd good step
      do_reset(5);
      check("reset_bin_out", 32'(bin_out), 32'd0);
      check("reset_locked",  32'(locked),  32'd0);
      t_in = cyc;
      send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010); send(4'b0110);
      idle(4);
      check("t1_count", 32'(q_bin.size()), 32'd5);
      for (int i = 0; i < 5; i++) check("t1_bin", 32'(q_bin[i]), 32'(e1[i]));
      check("t1_latency", 32'(q_cyc[0] - t_in), 32'd2);
      check("t1_unlocked_at_2", 32'(q_lock[2]), 32'd0);
      check("t1_locked_at_3", 32'(q_lock[3]), 32'd1);
      check("t1_dir", 32'(q_dir[4]), 32'd1);
      check("t1_no_err", 32'(sum_se()), 32'd0);

      // 2: upward wrap 15 -> 0
      do_reset(2);
      send(4'b1011); send(4'b1001); send(4'b1000); send(4'b0000); send(4'b0001);
      idle(4);
      check("t2_count", 32'(q_bin.size()), 32'd5);
      for (int i = 0; i < 5; i++) check("t2_bin", 32'(q_bin[i]), 32'(e2[i]));
      check("t2_locked_at_0", 32'(q_lock[3]), 32'd1);
      check("t2_dir", 32'(q_dir[4]), 32'd1);
      check("t2_no_err", 32'(sum_se()), 32'd0);

      // 3: downward wrap 0 -> 15, then hold
      do_reset(2);
      send(4'b0011); send(4'b0001); send(4'b0000); send(4'b1000); send(4'b1000);
      idle(4);
      check("t3_count", 32'(q_bin.size()), 32'd5);
      for (int i = 0; i < 5; i++) check("t3_bin", 32'(q_bin[i]), 32'(e3[i]));
      check("t3_dir_down", 32'(q_dir[1]), 32'd0);
      check("t3_dir_hold", 32'(q_dir[4]), 32'd0);
      check("t3_locked", 32'(q_lock[3]), 32'd1);
      check("t3_no_err", 32'(sum_se()), 32'd0);

      // 4: bad step from lock, recovery behaviour
      do_reset(2);
      send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010); send(4'b0110);
      send(4'b1100); send(4'b1101); send(4'b1111); send(4'b1110); send(4'b1010);
      idle(4);
      check("t4_count", 32'(q_bin.size()), 32'd10);
      check("t4_locked_pre", 32'(q_lock[4]), 32'd1);
      check("t4_bin_bad", 32'(q_bin[5]), 32'd8);
      check("t4_step_err", 32'(q_se[5]), 32'd1);
      check("t4_err_count", 32'(q_err[5]), 32'd1);
      check("t4_unlock", 32'(q_lock[5]), 32'd0);
      check("t4_after_fault", 32'(q_lock[6]), 32'd0);
      check("t4_no_err_after", 32'(q_se[6]), 32'd0);
`ifdef GRAY_STICKY_FAULT_EN
      check("t4_relock_12", 32'(q_lock[9]), 32'd0);
`else
      check("t4_relock_12", 32'(q_lock[9]), 32'd1);
`endif
      pulse_clr();
      idle(1);
      check("t4_clr", 32'(err_count), 32'd0);
      send(4'b1011); send(4'b1001); send(4'b1000);
      idle(4);
      check("t4_locked_15", 32'(q_lock[12]), 32'd1);

      // 5: reset while a sample is in flight
      do_reset(2);
      send(4'b0000);
      idle(3);
      clear_log();
      gray_in = 4'b0111; gray_valid = 1'b1;
      @(posedge clk); #1;
      gray_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(3);
      check("t5_dropped", 32'(q_bin.size()), 32'd0);
      check("t5_bin_out", 32'(bin_out), 32'd0);
      check("t5_locked", 32'(locked), 32'd0);
      send(4'b0111);
      idle(3);
      check("t5_seed_count", 32'(q_bin.size()), 32'd1);
      check("t5_seed_bin", 32'(q_bin[0]), 32'd5);
      check("t5_seed_no_err", 32'(q_se[0]), 32'd0);

      // 6: error counter saturation and clear
      do_reset(2);
      send(4'b0000); send(4'b1100); send(4'b0000); send(4'b1100); send(4'b0000);
      send(4'b1100);
      idle(3);
      check("t6_errs", 32'(sum_se()), 32'd5);
      check("t6_err_count", 32'(err_count), 32'd5);
      check("t6_err_sat", 32'(err_count2), 32'd3);
      pulse_clr();
      idle(1);
      check("t6_clr", 32'(err_count), 32'd0);
      check("t6_clr2", 32'(err_count2), 32'd0);
      // clear in the same cycle as a bad step (8 -> 0)
      gray_in = 4'b0000; gray_valid = 1'b1;
      @(posedge clk); #1;
      gray_valid = 1'b0; clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      idle(3);
      check("t6_same_cyc_pulse", 32'(q_se[q_se.size()-1]), 32'd1);
      check("t6_same_cyc_cnt", 32'(q_err[q_err.size()-1]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
